// File: rtl/output_ctrl_pkg.sv
// Shared definitions for the router output-port controller: polarity
// encodings (common with the input controller), flit width default and
// the port-index map used across the router.
package output_ctrl_pkg;

  localparam int DATA_WIDTH_DEF = 64;

  localparam logic [2:0] ST_IDLE = 3'b001;
  localparam logic [2:0] ST_ODD  = 3'b010;
  localparam logic [2:0] ST_EVEN = 3'b100;

  localparam int PORT_N  = 0;
  localparam int PORT_E  = 1;
  localparam int PORT_S  = 2;
  localparam int PORT_W  = 3;
  localparam int PORT_PE = 4;

  // IDLE enters ODD once, then ODD and EVEN alternate; anything else recovers to IDLE.
  function automatic logic [2:0] next_polarity(input logic [2:0] cur);
    logic [2:0] nxt;
    case (cur)
      ST_IDLE: nxt = ST_ODD;
      ST_ODD:  nxt = ST_EVEN;
      ST_EVEN: nxt = ST_ODD;
      default: nxt = ST_IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/output_ctrl_if.sv
// Bundle of the arbitration side (requests, flits, grants) and the
// downstream link handshake of one router output port.
interface output_ctrl_if
  import output_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_IN     = 4
);

  logic [NUM_IN-1:0]            req_in;
  logic [NUM_IN*DATA_WIDTH-1:0] data_in;
  logic [NUM_IN-1:0]            grant_out;
  logic                         receiveO;
  logic                         sendO;
  logic [DATA_WIDTH-1:0]        dataO;

  modport master (
    output req_in, data_in, receiveO,
    input  grant_out, sendO, dataO
  );

  modport slave (
    input  req_in, data_in, receiveO,
    output grant_out, sendO, dataO
  );

endinterface

// File: rtl/output_ctrl_rr_arbiter.sv
// Round-robin arbiter: scans requests starting at ptr and wrapping at
// NUM_IN-1 -> 0, granting the first active one when enabled.
module output_ctrl_rr_arbiter #(
  parameter int NUM_IN = 4,
  parameter int PTR_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  input  logic              enable,
  output logic [NUM_IN-1:0] grant,
  output logic [PTR_W-1:0]  winner,
  output logic              any_grant
);

  // First requester at or after the pointer wins; at most one grant bit is set.
  always_comb begin
    logic [PTR_W-1:0] idx;
    grant     = '0;
    winner    = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      idx = PTR_W'((int'(ptr) + k) % NUM_IN);
      if (enable && !any_grant && req[idx]) begin
        grant[idx] = 1'b1;
        winner     = idx;
        any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/output_ctrl_vc_buffer.sv
// Small FIFO used as one virtual-channel output buffer. Writes into a full
// buffer and reads from an empty one are ignored, so nothing is overwritten.
module output_ctrl_vc_buffer #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  do_wr;
  logic                  do_rd;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  // Storage and occupancy; reset clears the contents so the head reads as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= bump(wr_ptr);
      end
      if (do_rd) rd_ptr <= bump(rd_ptr);
      count <= count + CW'(do_wr) - CW'(do_rd);
    end
  end

endmodule

// File: rtl/output_ctrl.sv
// Router output-port controller. Each polarity writes one VC buffer (fed by
// the arbiter) and sends from the other, so a buffer is never written and
// read in the same cycle.
module output_ctrl
  import output_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int NUM_IN       = 4,
  parameter int BUFFER_DEPTH = 1
) (
  input logic        clk,
  input logic        rst,
  output_ctrl_if.slave bus
);

  localparam int PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic [2:0]            state;
  logic                  in_odd;
  logic                  in_even;
  logic [PTR_W-1:0]      rr_ptr_odd;
  logic [PTR_W-1:0]      rr_ptr_even;
  logic [PTR_W-1:0]      cur_ptr;
  logic [PTR_W-1:0]      next_ptr;
  logic [NUM_IN-1:0]     grant;
  logic [PTR_W-1:0]      winner;
  logic                  any_grant;
  logic                  arb_enable;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  odd_full, odd_empty, even_full, even_empty;
  logic [DATA_WIDTH-1:0] odd_head, even_head;
  logic                  src_full;
  logic                  send;

  assign in_odd  = (state == ST_ODD);
  assign in_even = (state == ST_EVEN);

  assign cur_ptr    = in_even ? rr_ptr_even : rr_ptr_odd;
  assign arb_enable = (in_odd & ~odd_full) | (in_even & ~even_full);
  assign next_ptr   = (winner == PTR_W'(NUM_IN - 1)) ? '0 : winner + PTR_W'(1);

  assign src_full = (in_odd & ~even_empty) | (in_even & ~odd_empty);
  assign send     = src_full & bus.receiveO;

  assign bus.grant_out = grant;
  assign bus.sendO     = send;
  assign bus.dataO     = in_even ? odd_head : even_head;

  output_ctrl_rr_arbiter #(
    .NUM_IN (NUM_IN),
    .PTR_W  (PTR_W)
  ) u_rr_arbiter (
    .req       (bus.req_in),
    .ptr       (cur_ptr),
    .enable    (arb_enable),
    .grant     (grant),
    .winner    (winner),
    .any_grant (any_grant)
  );

  // Select the granted input's flit slot for the write into the target VC.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant[i]) win_data = bus.data_in[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Polarity cycle: IDLE, then alternating ODD/EVEN.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_polarity(state);
  end

  // Only the pointer of the polarity that granted advances past its winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_odd  <= '0;
      rr_ptr_even <= '0;
    end else if (any_grant) begin
      if (in_odd)  rr_ptr_odd  <= next_ptr;
      if (in_even) rr_ptr_even <= next_ptr;
    end
  end

  output_ctrl_vc_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUFFER_DEPTH)
  ) u_odd_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (in_odd & any_grant),
    .wr_data (win_data),
    .rd_en   (in_even & send),
    .rd_data (odd_head),
    .full    (odd_full),
    .empty   (odd_empty)
  );

  output_ctrl_vc_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUFFER_DEPTH)
  ) u_even_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (in_even & any_grant),
    .wr_data (win_data),
    .rd_en   (in_odd & send),
    .rd_data (even_head),
    .full    (even_full),
    .empty   (even_empty)
  );

endmodule

// File: tb/tb_output_ctrl.sv
// Bench for output_ctrl: a 4-input and a 3-input instance driven with random
// requests, flits, backpressure and resets, checked against a phase/queue
// model of the port, plus a few fixed-value checks.
module tb_output_ctrl;

  logic clk;
  logic rst;

  output_ctrl_if #(.DATA_WIDTH(64), .NUM_IN(4)) bus4 ();
  output_ctrl_if #(.DATA_WIDTH(64), .NUM_IN(3)) bus3 ();

  output_ctrl #(.DATA_WIDTH(64), .NUM_IN(4), .BUFFER_DEPTH(1)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  output_ctrl #(.DATA_WIDTH(64), .NUM_IN(3), .BUFFER_DEPTH(1)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  int total = 0;
  int bad   = 0;

  // model: phase 0=idle 1=odd 2=even; vc 0=odd buffer 1=even buffer
  int          m_phase [2];
  int          m_ptr   [2][2];
  bit          m_full  [2][2];
  logic [63:0] m_data  [2][2];
  bit          m_known = 0;

  int          e_win   [2];
  bit          e_send  [2];
  logic [63:0] e_wdata [2];
  bit          e_rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic rs, input logic [3:0] r4, input logic [2:0] r3,
                               input logic c4, input logic c3);
    @(negedge clk);
    rst           = rs;
    bus4.req_in   = r4;
    bus3.req_in   = r3;
    bus4.receiveO = c4;
    bus3.receiveO = c3;
    for (int i = 0; i < 4; i++) bus4.data_in[i*64 +: 64] = {$urandom, $urandom};
    for (int i = 0; i < 3; i++) bus3.data_in[i*64 +: 64] = {$urandom, $urandom};
  endtask

  task automatic compareModel();
    logic [3:0]  req;
    logic        rcv;
    logic [3:0]  got_g;
    logic        got_s;
    logic [63:0] got_d;
    int n, w, s, idx;
    #1;
    e_rst = rst;
    for (int u = 0; u < 2; u++) begin
      n = (u == 0) ? 4 : 3;
      if (u == 0) begin
        req = bus4.req_in; rcv = bus4.receiveO;
        got_g = bus4.grant_out; got_s = bus4.sendO; got_d = bus4.dataO;
      end else begin
        req = {1'b0, bus3.req_in}; rcv = bus3.receiveO;
        got_g = {1'b0, bus3.grant_out}; got_s = bus3.sendO; got_d = bus3.dataO;
      end
      w = (m_phase[u] == 2) ? 1 : 0;
      s = 1 - w;
      e_win[u]   = -1;
      e_send[u]  = 0;
      e_wdata[u] = '0;
      if (m_phase[u] != 0) begin
        if (!m_full[u][w]) begin
          for (int k = 0; k < n; k++) begin
            idx = (m_ptr[u][w] + k) % n;
            if (e_win[u] < 0 && req[idx]) e_win[u] = idx;
          end
        end
        e_send[u] = m_full[u][s] && rcv;
      end
      if (e_win[u] >= 0)
        e_wdata[u] = (u == 0) ? bus4.data_in[e_win[u]*64 +: 64] : bus3.data_in[e_win[u]*64 +: 64];
      if (m_known) begin
        checkOutput($sformatf("grant_n%0d", n), 64'(got_g),
                    (e_win[u] >= 0) ? (64'd1 << e_win[u]) : 64'd0);
        checkOutput($sformatf("sendO_n%0d", n), 64'(got_s), 64'(e_send[u]));
        if (e_send[u])
          checkOutput($sformatf("dataO_n%0d", n), got_d, m_data[u][s]);
        else if (m_phase[u] == 0)
          checkOutput($sformatf("idle_dataO_n%0d", n), got_d, 64'd0);
      end
    end
  endtask

  task automatic advance();
    int n, w, s;
    @(posedge clk);
    for (int u = 0; u < 2; u++) begin
      n = (u == 0) ? 4 : 3;
      if (e_rst) begin
        m_phase[u] = 0;
        for (int v = 0; v < 2; v++) begin
          m_ptr[u][v] = 0; m_full[u][v] = 0; m_data[u][v] = '0;
        end
      end else begin
        w = (m_phase[u] == 2) ? 1 : 0;
        s = 1 - w;
        if (e_send[u]) m_full[u][s] = 0;
        if (e_win[u] >= 0) begin
          m_full[u][w] = 1;
          m_data[u][w] = e_wdata[u];
          m_ptr[u][w]  = (e_win[u] + 1) % n;
        end
        m_phase[u] = (m_phase[u] == 1) ? 2 : 1;
      end
    end
    if (e_rst) m_known = 1;
  endtask

  task automatic runCycle(input logic rs, input logic [3:0] r4, input logic [2:0] r3,
                          input logic c4, input logic c3);
    applyStimulus(rs, r4, r3, c4, c3);
    compareModel();
    advance();
  endtask

  initial begin
    logic [3:0] r4;
    logic [2:0] r3;
    bit         stall;

    // reset, then the idle cycle
    runCycle(1, 4'h0, 3'h0, 0, 0);
    runCycle(1, 4'h0, 3'h0, 0, 0);
    applyStimulus(0, 4'h0, 3'h0, 1, 1);
    compareModel();
    checkOutput("reset_idle_grant", 64'(bus4.grant_out), 64'd0);
    checkOutput("reset_idle_sendO", 64'(bus4.sendO), 64'd0);
    checkOutput("reset_idle_dataO", bus4.dataO, 64'd0);
    advance();

    // single request in the first ODD cycle, sent in the following EVEN cycle
    applyStimulus(0, 4'b0100, 3'b000, 1, 1);
    bus4.data_in[2*64 +: 64] = 64'hA5A5;
    compareModel();
    checkOutput("single_grant", 64'(bus4.grant_out), 64'b0100);
    advance();
    applyStimulus(0, 4'b0000, 3'b000, 1, 1);
    compareModel();
    checkOutput("single_sendO", 64'(bus4.sendO), 64'd1);
    checkOutput("single_dataO", bus4.dataO, 64'hA5A5);
    advance();

    // all inputs requesting, then backpressure
    repeat (8) runCycle(0, 4'hF, 3'h7, 1, 1);
    repeat (6) runCycle(0, 4'hF, 3'h5, 0, 0);
    repeat (4) runCycle(0, 4'hF, 3'h5, 1, 1);

    // random traffic with bursts of stalls and occasional resets
    stall = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 29) == 0) stall = ~stall;
      r4 = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom);
      r3 = ($urandom_range(0, 4) == 0) ? 3'h0 : 3'($urandom);
      runCycle($urandom_range(0, 249) == 0, r4, r3,
               stall ? 1'b0 : ($urandom_range(0, 9) < 7),
               stall ? 1'b0 : ($urandom_range(0, 9) < 7));
    end

    // fill both buffers, reset mid-flight; the old flits must never appear
    repeat (3) runCycle(0, 4'hF, 3'h7, 0, 0);
    runCycle(1, 4'hF, 3'h7, 0, 0);
    applyStimulus(0, 4'h0, 3'h0, 1, 1);
    compareModel();
    checkOutput("midreset_idle_sendO", 64'(bus4.sendO), 64'd0);
    checkOutput("midreset_idle_grant", 64'(bus4.grant_out), 64'd0);
    advance();
    applyStimulus(0, 4'h0, 3'h0, 1, 1);
    compareModel();
    checkOutput("midreset_odd_sendO", 64'(bus4.sendO), 64'd0);
    checkOutput("midreset_odd_sendO_n3", 64'(bus3.sendO), 64'd0);
    advance();
    applyStimulus(0, 4'h0, 3'h0, 1, 1);
    compareModel();
    checkOutput("midreset_even_sendO", 64'(bus4.sendO), 64'd0);
    advance();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/output_ctrl.md
Name: output_ctrl

Overview:
- Router output-port controller: arbitrates the NUM_IN input controllers requesting this output port and owns the port's even/odd virtual-channel output buffers.
- Drives the downstream link handshake (sendO/receiveO).
- Runs the same IDLE/ODD/EVEN polarity cycle as the input side. Each polarity has an internal write VC and an external send VC, so no buffer is written and read in the same cycle.

Parameters:
- DATA_WIDTH, 64, flit width.
- NUM_IN, 4, number of requesting input controllers (N/E/S/W or PE).
- BUFFER_DEPTH, 1, depth of each VC output buffer.
- PTR_W, $clog2(NUM_IN), round-robin pointer width (derived, not overridden).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- req_in  input  NUM_IN  per-input request (sig_req_channel of each input controller).
- data_in  input  NUM_IN*DATA_WIDTH  per-input flit (inner_dataO); slot i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- grant_out  output  NUM_IN  one-hot grant (sig_channel_clean to each input controller); pops that input's buffer.
- receiveO  input  1  downstream ready.
- sendO  output  1  flit valid to downstream.
- dataO  output  DATA_WIDTH  flit to downstream.

Behaviour:
- Polarity FSM:
  - States IDLE=3'b001, ODD=3'b010, EVEN=3'b100.
  - Transitions: IDLE->ODD, ODD->EVEN, EVEN->ODD; an illegal state goes to IDLE.
  - rst forces IDLE.
- Buffer roles:
  - ODD: write target = odd_buf, send source = even_buf.
  - EVEN: write target = even_buf, send source = odd_buf.
  - IDLE: no write, no send.
- Arbitration (combinational, same cycle as the request):
  - Grants only when the write target is empty.
  - Round-robin over req_in, starting at the pointer of the current polarity (rr_ptr_odd in ODD, rr_ptr_even in EVEN).
  - grant_out is one-hot or zero.
  - Winner's data_in slot is written into the target buffer at the clock edge.
  - On a grant, that polarity's pointer becomes (winner+1) mod NUM_IN. The other pointer holds.
  - No request, or target full: grant_out=0 and both pointers hold.
- Send:
  - sendO = send-source full AND receiveO.
  - When sendO=1 the source buffer pops at the edge.
  - dataO = send-source buffer head, driven continuously.
  - receiveO low: source holds; sendO=0.
- Latency:
  - A request granted in cycle n (e.g. ODD) is in odd_buf from n+1 (EVEN).
  - It is sent in n+1 if receiveO=1, otherwise in the next EVEN cycle with receiveO=1.
  - Minimum request-to-sendO latency: 1 cycle.
- Simultaneous events:
  - A write to one VC and a send from the other VC in the same cycle are always legal; they never target the same buffer.
  - Multiple requests: exactly one winner per cycle. Losers keep requesting and are not starved: each waits at most NUM_IN-1 grants of that polarity.
- Full/empty: a target full for consecutive same-polarity cycles blocks all grants; no data is overwritten.
- Reset values (also on reset mid-operation):
  - State IDLE; both pointers 0.
  - Buffers empty; in-flight flits are discarded.
  - grant_out=0, sendO=0, dataO = buffer reset value (0).
- Width rules: the pointer wraps modulo NUM_IN; a non-power-of-2 NUM_IN wraps at NUM_IN-1 -> 0, not at 2^PTR_W.

Decomposition:
- Shared package:
  - Polarity state constants IDLE/ODD/EVEN (shared with the input controller).
  - DATA_WIDTH default.
  - Port-index constants (N/E/S/W/PE).
- Sub-module rr_arbiter:
  - Parameter NUM_IN.
  - Inputs: req, ptr, enable.
  - Outputs: one-hot grant, winner index, any_grant.
  - Instantiated once; the pointer is muxed by polarity.
- Reuse the existing buffer module for both VC buffers.

Test Plan:
- Reset then idle: after rst deasserts, cycle 1 IDLE with grant_out=0 and sendO=0; cycle 2 state ODD.
- Single request: req_in=4'b0100 with data slot2=64'hA5A5 during ODD, receiveO=1 -> grant_out=4'b0100 that cycle; next cycle (EVEN) sendO=1, dataO=64'hA5A5; rr_ptr_odd=3.
- Round robin: req_in=4'b1111 held, receiveO=1, for 8 cycles -> ODD grants 0,1,2,3 and EVEN grants 0,1,2,3 in order, each exactly once; grant_out always one-hot.
- Backpressure: receiveO=0 with odd_buf full -> no grant in later ODD cycles, sendO=0, dataO stable. Raise receiveO -> flit sent in the next EVEN cycle, then the grant resumes at the following ODD cycle.
- Wrap/odd NUM_IN: NUM_IN=3 with rr_ptr_odd=2, req_in=3'b101 -> winner 2, pointer wraps to 0; next ODD with 3'b101 -> winner 0.
- Reset mid-flight: both buffers full, assert rst for one cycle -> sendO=0, grant_out=0, buffers empty, pointers 0, state IDLE; the old flit is never emitted.
